// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit: opcodes,
// state encodings, mux select codes and the control vector.
package mc_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXE_R    = 4'd3,
        ST_EXE_I    = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_WB_I     = 4'd9,
        ST_WB_MEM   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_WB_LUI   = 4'd13
    } state_e;

    localparam logic [2:0] NPC_PC4 = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;
    localparam logic [1:0] M2R_LUI = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [2:0] npc_sel;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic       ext_op;
        logic [1:0] alu_ctr;
    } ctrl_t;

    // Instruction dispatch out of DECODE; nop (sll) and unknown encodings retire at once.
    function automatic state_e dispatch(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB: return ST_EXE_R;
                    FN_JR:                   return ST_JUMP;
                    FN_SLL:                  return ST_FETCH;
                    default:                 return ST_FETCH;
                endcase
            end
            OP_ORI:        return ST_EXE_I;
            OP_LW, OP_SW:  return ST_MEM_ADDR;
            OP_BEQ:        return ST_BRANCH;
            OP_LUI:        return ST_WB_LUI;
            OP_J, OP_JAL:  return ST_JUMP;
            default:       return ST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_out_decode.sv
// Moore output decode: control vector from the current state and the IR fields,
// with pc_we/ir_we qualified by mem_ready (fetch) and zero (branch).
module mc_out_decode
    import mc_defs::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output ctrl_t      ctrl_o
);

    // NOTE: the whole vector gets a default before the case so no output can infer a latch.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b0;
                ctrl_o.npc_sel = NPC_PC4;
                if (mem_ready_i) begin
                    ctrl_o.ir_we = 1'b1;
                    ctrl_o.pc_we = 1'b1;
                end
            end
            ST_EXE_R: begin
                ctrl_o.alu_src = 1'b0;
                ctrl_o.alu_ctr = (funct_i == FN_SUB) ? ALU_SUB : ALU_ADD;
            end
            ST_WB_R: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.reg_dst    = RD_RD;
                ctrl_o.mem_to_reg = M2R_ALU;
            end
            ST_EXE_I: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.ext_op  = 1'b0;
                ctrl_o.alu_ctr = ALU_OR;
            end
            ST_WB_I: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.reg_dst    = RD_RT;
                ctrl_o.mem_to_reg = M2R_ALU;
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.ext_op  = 1'b1;
                ctrl_o.alu_ctr = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
                ctrl_o.mem_we  = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.reg_dst    = RD_RT;
                ctrl_o.mem_to_reg = M2R_MDR;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src = 1'b0;
                ctrl_o.alu_ctr = ALU_SUB;
                ctrl_o.npc_sel = NPC_BR;
                ctrl_o.pc_we   = zero_i;
            end
            ST_JUMP: begin
                ctrl_o.pc_we = 1'b1;
                if (op_i == OP_RTYPE && funct_i == FN_JR) begin
                    ctrl_o.npc_sel = NPC_JR;
                end else begin
                    ctrl_o.npc_sel = NPC_J;
                end
                if (op_i == OP_JAL) begin
                    ctrl_o.reg_we     = 1'b1;
                    ctrl_o.reg_dst    = RD_RA;
                    ctrl_o.mem_to_reg = M2R_PC;
                end
            end
            ST_WB_LUI: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.reg_dst    = RD_RT;
                ctrl_o.mem_to_reg = M2R_LUI;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control unit: state register, next-state logic and retired-instruction
// counter. Outputs decode straight from the state register, so reset drops them at once.
module mc_ctrl_fsm
    import mc_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [2:0]       npc_sel,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src,
    output logic             ext_op,
    output logic [1:0]       alu_ctr,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    ctrl_t            ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE:   state_d = dispatch(op, funct);
            ST_EXE_R:    state_d = ST_WB_R;
            ST_EXE_I:    state_d = ST_WB_I;
            ST_MEM_ADDR: state_d = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            ST_WB_R, ST_WB_I, ST_WB_MEM,
            ST_BRANCH, ST_JUMP, ST_WB_LUI: state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    // A fetch stall is a self-loop, not a retirement; only arrivals from other states count.
    assign retire = (state_d == ST_FETCH) && (state_q != ST_IDLE) && (state_q != ST_FETCH);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    mc_out_decode u_out_decode (
        .state_i     (state_q),
        .op_i        (op),
        .funct_i     (funct),
        .mem_ready_i (mem_ready),
        .zero_i      (zero),
        .ctrl_o      (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign iord       = ctrl.iord;
    assign ir_we      = ctrl.ir_we;
    assign pc_we      = ctrl.pc_we;
    assign npc_sel    = ctrl.npc_sel;
    assign reg_we     = ctrl.reg_we;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src    = ctrl.alu_src;
    assign ext_op     = ctrl.ext_op;
    assign alu_ctr    = ctrl.alu_ctr;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule
